// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback-side signal bundle for the register-file scoreboard.
// The decode side drives the master modport and the scoreboard uses the slave modport.
interface regfile_scoreboard_if;
    // Issue handshake: an instruction moves from decode into execute on a rising
    // edge where issue_valid & issue_accept are both high. issue_accept is
    // combinational and never depends on itself. Decode holds its instruction
    // stable while stall is high.
    logic       issue_valid;
    logic       issue_writes;
    logic [2:0] issue_dest;
    logic [2:0] src_a;
    logic [2:0] src_b;
    logic       src_a_used;
    logic       src_b_used;
    logic       wb_load;
    logic [2:0] wb_dest;
    logic       flush;
    logic       stall;
    logic       issue_accept;
    logic [7:0] busy;
    logic       sb_error;

    modport master (
        output issue_valid, issue_writes, issue_dest, src_a, src_b,
               src_a_used, src_b_used, wb_load, wb_dest, flush,
        input  stall, issue_accept, busy, sb_error
    );

    modport slave (
        input  issue_valid, issue_writes, issue_dest, src_a, src_b,
               src_a_used, src_b_used, wb_load, wb_dest, flush,
        output stall, issue_accept, busy, sb_error
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register in-flight write counters that stall LC-3b decode on RAW hazards.
// Define REGFILE_SB_BYPASS_EN to release a consumer in its producer's writeback cycle.
module regfile_scoreboard #(
    parameter int MAX_INFLIGHT = 3
) (
    input logic                 clk,
    input logic                 reset,
    regfile_scoreboard_if.slave sb
);
    localparam int CW = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_INFLIGHT);
    localparam logic [CW-1:0] ONE_CNT = CW'(1);

    logic [CW-1:0] count [8];
    logic [7:0]    pend;
    logic [7:0]    inc;
    logic [7:0]    dec;
    logic          hazard;
    logic          err_q;

    always_comb begin
        pend = '0;
        for (int r = 0; r < 8; r++) begin
`ifdef REGFILE_SB_BYPASS_EN
            // The regfile writes before it reads, so the last retiring producer's
            // value is already visible to a same-cycle reader.
            pend[r] = (count[r] != '0) &
                      ~(sb.wb_load & (sb.wb_dest == 3'(r)) & (count[r] == ONE_CNT));
`else
            pend[r] = (count[r] != '0);
`endif
        end
    end

    // The saturation check always uses the raw count, never the bypassed pend term.
    assign hazard = (sb.src_a_used & pend[sb.src_a]) |
                    (sb.src_b_used & pend[sb.src_b]) |
                    (sb.issue_writes & (count[sb.issue_dest] == MAX_CNT));

    assign sb.stall        = sb.issue_valid & hazard;
    assign sb.issue_accept = sb.issue_valid & ~sb.stall;

    always_comb begin
        inc = '0;
        dec = '0;
        for (int r = 0; r < 8; r++) begin
            inc[r] = sb.issue_accept & sb.issue_writes & (sb.issue_dest == 3'(r));
            dec[r] = sb.wb_load & (sb.wb_dest == 3'(r)) & (count[r] != '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < 8; r++) begin
                count[r] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int r = 0; r < 8; r++) begin
                if (sb.flush) begin
                    count[r] <= '0;
                end else begin
                    count[r] <= count[r] + CW'(inc[r]) - CW'(dec[r]);
                end
            end
            // Retiring a register with nothing pending means bookkeeping went wrong.
            if (sb.wb_load && (count[sb.wb_dest] == '0)) begin
                err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        sb.busy = '0;
        for (int r = 0; r < 8; r++) begin
            sb.busy[r] = (count[r] != '0);
        end
    end

    assign sb.sb_error = err_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: a cycle-by-cycle vector table
// followed by hand-written reset sequences.
module tb_regfile_scoreboard;
    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    regfile_scoreboard_if sbif ();

    regfile_scoreboard #(.MAX_INFLIGHT(3)) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sbif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic       writes;
        logic [2:0] dest;
        logic [2:0] sa;
        logic       sa_used;
        logic [2:0] sb;
        logic       sb_used;
        logic       wb;
        logic [2:0] wd;
        logic       fl;
        logic       e_stall;
        logic       e_acc;
        logic [7:0] e_busy;
        logic       e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic v, input logic w, input logic [2:0] d,
        input logic [2:0] sa, input logic sau, input logic [2:0] sb, input logic sbu,
        input logic wl, input logic [2:0] wd, input logic fl,
        input logic es, input logic ea, input logic [7:0] eb, input logic ee);
        vec_t t;
        t.valid = v; t.writes = w; t.dest = d;
        t.sa = sa; t.sa_used = sau; t.sb = sb; t.sb_used = sbu;
        t.wb = wl; t.wd = wd; t.fl = fl;
        t.e_stall = es; t.e_acc = ea; t.e_busy = eb; t.e_err = ee;
        return t;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h, expected %02h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        sbif.issue_valid  = 1'b0;
        sbif.issue_writes = 1'b0;
        sbif.issue_dest   = 3'd0;
        sbif.src_a        = 3'd0;
        sbif.src_b        = 3'd0;
        sbif.src_a_used   = 1'b0;
        sbif.src_b_used   = 1'b0;
        sbif.wb_load      = 1'b0;
        sbif.wb_dest      = 3'd0;
        sbif.flush        = 1'b0;
    endtask

    task automatic drive_vec(input vec_t t);
        sbif.issue_valid  = t.valid;
        sbif.issue_writes = t.writes;
        sbif.issue_dest   = t.dest;
        sbif.src_a        = t.sa;
        sbif.src_b        = t.sb;
        sbif.src_a_used   = t.sa_used;
        sbif.src_b_used   = t.sb_used;
        sbif.wb_load      = t.wb;
        sbif.wb_dest      = t.wd;
        sbif.flush        = t.fl;
    endtask

    initial begin
        logic bypass;
        n_vec = 0;
        n_err = 0;
`ifdef REGFILE_SB_BYPASS_EN
        bypass = 1'b1;
`else
        bypass = 1'b0;
`endif
        //         v  w  d    sa  au sb  bu wl wd  fl  stall acc busy   err
        vecs.push_back(mk(1, 0, 0,  2, 1, 0, 0, 0, 0, 0, 0, 1, 8'h00, 0)); // 0 idle read
        vecs.push_back(mk(1, 1, 3,  0, 0, 0, 0, 0, 0, 0, 0, 1, 8'h00, 0)); // 1 write R3
        vecs.push_back(mk(1, 0, 0,  3, 0, 0, 0, 0, 0, 0, 0, 1, 8'h08, 0)); // 2 unused src
        vecs.push_back(mk(1, 0, 0,  0, 0, 3, 1, 0, 0, 0, 1, 0, 8'h08, 0)); // 3 RAW stall
        vecs.push_back(mk(1, 0, 0,  0, 0, 3, 1, 1, 3, 0, ~bypass, bypass, 8'h08, 0)); // 4 wb cycle
        vecs.push_back(mk(1, 0, 0,  0, 0, 3, 1, 0, 0, 0, 0, 1, 8'h00, 0)); // 5 released
        vecs.push_back(mk(1, 1, 5,  0, 0, 0, 0, 0, 0, 0, 0, 1, 8'h00, 0)); // 6 R5 #1
        vecs.push_back(mk(1, 1, 5,  0, 0, 0, 0, 0, 0, 0, 0, 1, 8'h20, 0)); // 7 R5 #2
        vecs.push_back(mk(1, 1, 5,  0, 0, 0, 0, 0, 0, 0, 0, 1, 8'h20, 0)); // 8 R5 #3
        vecs.push_back(mk(1, 1, 5,  0, 0, 0, 0, 0, 0, 0, 1, 0, 8'h20, 0)); // 9 saturated
        vecs.push_back(mk(1, 1, 5,  0, 0, 0, 0, 1, 5, 0, 1, 0, 8'h20, 0)); // 10 sat + wb
        vecs.push_back(mk(1, 1, 5,  0, 0, 0, 0, 0, 0, 0, 0, 1, 8'h20, 0)); // 11 fourth issues
        vecs.push_back(mk(1, 1, 1,  0, 0, 0, 0, 0, 0, 0, 0, 1, 8'h20, 0)); // 12 write R1
        vecs.push_back(mk(1, 1, 1,  0, 0, 0, 0, 1, 1, 0, 0, 1, 8'h22, 0)); // 13 inc+dec R1
        vecs.push_back(mk(0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h22, 0)); // 14 R1 still 1
        vecs.push_back(mk(1, 1, 2,  2, 1, 2, 1, 0, 0, 0, 0, 1, 8'h22, 0)); // 15 src==dest
        vecs.push_back(mk(0, 0, 0,  0, 0, 0, 0, 1, 6, 0, 0, 0, 8'h26, 0)); // 16 underflow R6
        vecs.push_back(mk(0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h26, 1)); // 17 sticky err
        vecs.push_back(mk(1, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0, 1, 8'h26, 1)); // 18 write R0
        vecs.push_back(mk(1, 1, 4,  0, 0, 0, 0, 0, 0, 0, 0, 1, 8'h27, 1)); // 19 write R4
        vecs.push_back(mk(1, 1, 7,  0, 0, 0, 0, 0, 0, 0, 0, 1, 8'h37, 1)); // 20 write R7
        vecs.push_back(mk(1, 1, 0,  7, 1, 0, 0, 1, 5, 1, 1, 0, 8'hB7, 1)); // 21 flush
        vecs.push_back(mk(1, 0, 0,  7, 1, 0, 0, 0, 0, 0, 0, 1, 8'h00, 1)); // 22 cleared
        vecs.push_back(mk(1, 1, 3,  0, 0, 5, 1, 0, 0, 0, 0, 1, 8'h00, 1)); // 23 write R3

        drive_idle();
        reset = 1'b1;
        #2;
        check("reset busy",     sbif.busy, 8'h00);
        check("reset sb_error", {7'd0, sbif.sb_error}, 8'h00);
        check("reset stall",    {7'd0, sbif.stall}, 8'h00);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive_vec(vecs[i]);
            #1;
            check($sformatf("vec%0d stall", i),  {7'd0, sbif.stall},        {7'd0, vecs[i].e_stall});
            check($sformatf("vec%0d accept", i), {7'd0, sbif.issue_accept}, {7'd0, vecs[i].e_acc});
            check($sformatf("vec%0d busy", i),   sbif.busy,                 vecs[i].e_busy);
            check($sformatf("vec%0d err", i),    {7'd0, sbif.sb_error},     {7'd0, vecs[i].e_err});
        end

        // R3 pending, sb_error set: asynchronous reset must clear everything mid-cycle.
        @(negedge clk);
        drive_idle();
        sbif.issue_valid = 1'b1;
        sbif.src_a       = 3'd3;
        sbif.src_a_used  = 1'b1;
        #1;
        check("pre-reset stall", {7'd0, sbif.stall}, 8'h01);
        check("pre-reset busy",  sbif.busy, 8'h08);
        #1;
        reset = 1'b1;
        #1;
        check("async stall",  {7'd0, sbif.stall}, 8'h00);
        check("async accept", {7'd0, sbif.issue_accept}, 8'h01);
        check("async busy",   sbif.busy, 8'h00);
        check("async err",    {7'd0, sbif.sb_error}, 8'h00);
        drive_idle();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post-reset busy", sbif.busy, 8'h00);
        check("post-reset err",  {7'd0, sbif.sb_error}, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Register-file scoreboard and issue controller for the LC-3b pipeline's decode stage. It counts in-flight writes per architectural register (R0–R7) and holds the instruction in decode while any source it reads has a write still pending downstream. Pending writes retire when the writeback stage loads the register file. The block decides when decode may issue into execute; it owns no datapath storage beyond its counters.

## Interface
Parameters:
- MAX_INFLIGHT, default 3: maximum outstanding writes tracked per register. Counter width is CW = $clog2(MAX_INFLIGHT+1).

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- issue_valid  in  1  decode holds a valid instruction that wants to advance.
- issue_writes  in  1  that instruction writes the register file.
- issue_dest  in  3  destination register (IR[11:9], or 3'b111 for R7 writers).
- src_a, src_b  in  3 each  register numbers that decode presents to the regfile read ports.
- src_a_used, src_b_used  in  1 each  the corresponding source operand is actually consumed.
- wb_load  in  1  writeback loads the register file this cycle.
- wb_dest  in  3  register written by writeback.
- flush  in  1  squash all in-flight instructions.
- stall  out  1  hold decode and the IF/ID latch.
- issue_accept  out  1  = issue_valid & ~stall.
- busy  out  8  bit r = (count[r] != 0), from registered state.
- sb_error  out  1  sticky flag: writeback retired a register that had no pending write.

## Operation
- State: count[0..7], each CW bits wide, plus the sb_error flop.
- The hazard term is the OR of three conditions:
  - (src_a_used & pend(src_a))
  - (src_b_used & pend(src_b))
  - (issue_writes & count[issue_dest] == MAX_INFLIGHT)
- stall = issue_valid & hazard. When issue_valid = 0, stall = 0.
- pend(r) = (count[r] != 0), except as modified in Configuration.
- Per-register update, when flush = 0:
  - inc[r] = issue_accept & issue_writes & (issue_dest == r)
  - dec[r] = wb_load & (wb_dest == r) & (count[r] != 0)
  - count[r] <= count[r] + inc[r] - dec[r], computed in CW bits.
  - When inc and dec hit the same register in the same cycle, the count is unchanged.
- Underflow: if wb_load = 1 and count[wb_dest] == 0, the count stays 0 and sb_error <= 1. sb_error is cleared only by reset.
- Overflow cannot occur, because the saturation term in hazard stalls the issue first.
- flush = 1 sets every count to 0 on the next edge.
  - issue and wb_load are ignored for counting in that cycle.
  - stall is still computed normally in that cycle.
- Source checks and the destination check use the same registered counts. An instruction whose source equals its destination stalls only on the source's pending state.

## Timing
- stall, issue_accept and hazard are combinational from inputs and registered counts. They are valid in the same cycle, with zero latency.
- busy and sb_error are registered outputs.
- Counter updates become visible one cycle after the accepting or retiring edge.
- Reset values: all counts 0; busy = 8'h00; sb_error = 0; stall = 0 (given issue_valid = 0 during reset).
- If reset is asserted mid-stall, stall drops immediately because all counts clear asynchronously.
- With the default configuration, for a back-to-back producer→consumer pair:
  - The consumer stalls until the cycle after the producer's wb_load.
  - It issues on the first cycle where count = 0.

## Configuration
- REGFILE_SB_BYPASS_EN:
  - Defined: pend(r) = (count[r] != 0) & ~(wb_load & wb_dest == r & count[r] == 1). A consumer issues in the same cycle its last pending producer writes back. This relies on the regfile write-before-read behaviour.
  - Undefined: pend(r) = (count[r] != 0). The consumer issues one cycle later.
  - In both cases the saturation check is unaffected.

## Test plan
- Reset, then issue_valid = 1 with src_a = 2 used, no writes pending → stall = 0, busy = 8'h00.
- Accept a write to R3; next cycle present src_b = 3 used → stall = 1 and busy[3] = 1. Pulse wb_load with wb_dest = 3:
  - Without the macro: stall = 1 that cycle, 0 the next.
  - With REGFILE_SB_BYPASS_EN: stall = 0 in the wb_load cycle.
- Issue 3 writes to R5 (MAX_INFLIGHT = 3), then a fourth write to R5 → stall = 1. A wb_load to R5 drops the count to 2 and the fourth issues on the next cycle.
- Same cycle: accept a write to R1 while wb_load retires R1 with count = 1 → count stays 1, busy[1] = 1.
- wb_load to R6 with count[6] = 0 → sb_error = 1 and stays 1; count[6] stays 0.
- With counts pending on R0, R4 and R7, assert flush → next cycle busy = 8'h00. Assert reset asynchronously mid-cycle → all counts and sb_error clear before the next edge.
